// File: rtl/rot_shamt_reduce_if.sv
// rtl/rot_shamt_reduce_if.sv - operand and result handshake bundle for rot_shamt_reduce
interface rot_shamt_reduce_if #(
    parameter int DATA_WIDTH  = 20,
    parameter int SHAMT_WIDTH = 5
);
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  data_in;
    logic [DATA_WIDTH-1:0]  shift_amount;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  data_out;
    logic [SHAMT_WIDTH-1:0] shamt_out;

    modport master (
        output in_valid, data_in, shift_amount, out_ready,
        input  in_ready, out_valid, data_out, shamt_out
    );

    modport slave (
        input  in_valid, data_in, shift_amount, out_ready,
        output in_ready, out_valid, data_out, shamt_out
    );
endinterface

// File: rtl/rot_shamt_reduce.sv
// rtl/rot_shamt_reduce.sv - reduces a full-width rotate amount modulo DATA_WIDTH, one bit per cycle
module rot_shamt_reduce #(
    parameter int DATA_WIDTH  = 20,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    rot_shamt_reduce_if.slave bus
);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [SHAMT_WIDTH:0] MODULUS = (SHAMT_WIDTH+1)'(DATA_WIDTH);
    localparam logic [IDX_W-1:0]     IDX_TOP = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        DONE
    } state_t;

    state_t                 state_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [DATA_WIDTH-1:0]  amt_q;
    logic [DATA_WIDTH-1:0]  data_out_q;
    logic [SHAMT_WIDTH-1:0] rem_q;
    logic [SHAMT_WIDTH-1:0] shamt_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   in_ready_q;
    logic                   out_valid_q;

    logic [SHAMT_WIDTH:0]   t;
    logic [SHAMT_WIDTH:0]   t_sub;
    logic [SHAMT_WIDTH-1:0] rem_d;

    // Restoring remainder step: t < 2*DATA_WIDTH, so one conditional subtract suffices
    always_comb begin
        t     = {rem_q, amt_q[idx_q]};
        t_sub = t - MODULUS;
        rem_d = (t >= MODULUS) ? t_sub[SHAMT_WIDTH-1:0] : t[SHAMT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            amt_q       <= '0;
            data_out_q  <= '0;
            rem_q       <= '0;
            shamt_q     <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        data_q     <= bus.data_in;
                        amt_q      <= bus.shift_amount;
                        rem_q      <= '0;
                        idx_q      <= IDX_TOP;
                        in_ready_q <= 1'b0;
                        state_q    <= REDUCE;
                    end
                end
                REDUCE: begin
                    rem_q <= rem_d;
                    if (idx_q == '0) begin
                        data_out_q  <= data_q;
                        shamt_q     <= rem_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.shamt_out = shamt_q;
endmodule
